// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared definitions for the multicycle datapath. Contains the
//                opcode/function codes, ALU operation codes, the bit
//                positions of the external control word, the FSM state
//                type and the register-file geometry.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

  // Major opcodes, instruction[15:12]
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type function codes, instruction[5:0]
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALUOp encodings carried in controls[4:1]
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_TCP = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;

  // Bit positions inside the 12-bit control word
  localparam int CTL_WIDTH    = 12;
  localparam int CTL_ALUSRC   = 0;
  localparam int CTL_ALUOP_LO = 1;
  localparam int CTL_ALUOP_HI = 4;
  localparam int CTL_REGWRITE = 5;
  localparam int CTL_REGDST   = 6;
  localparam int CTL_MEMWRITE = 7;
  localparam int CTL_MEMREAD  = 8;
  localparam int CTL_MEMTOREG = 9;
  localparam int CTL_BRANCH   = 10;
  localparam int CTL_JUMP     = 11;

  // Register file geometry
  localparam int NUM_REGS   = 4;
  localparam int REG_ADDR_W = 2;

  typedef enum logic [1:0] {
    S_IF  = 2'd0,
    S_EX  = 2'd1,
    S_MEM = 2'd2,
    S_WB  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/datapath_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_regfile
//  Description : 4 x WORD_SIZE register file, two asynchronous read ports and
//                one synchronous write port, synchronous active-high reset.
//  Ports       : clk, reset          - clock / sync reset (clears all entries)
//                raddr1/rdata1       - read port 1
//                raddr2/rdata2       - read port 2
//                we, waddr, wdata    - write port (posedge clk)
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_regfile
  import datapath_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [WORD_SIZE-1:0]  rdata1,
  output logic [WORD_SIZE-1:0]  rdata2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WORD_SIZE-1:0]  wdata
);

  logic [WORD_SIZE-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign rdata1 = r_regs[raddr1];
  assign rdata2 = r_regs[raddr2];

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_datapath
//  Description : Multicycle (IF/EX/MEM/WB) datapath for the 16-bit-instruction
//                ISA. Control bits come from an external control unit and are
//                captured in EX; RF and PC are committed only in WB.
//  Ports       : clk, reset                - clock / sync active-high reset
//                controls[11:0]            - {Jump,Branch,MemtoReg,MemRead,
//                                             MemWrite,RegDst,RegWrite,
//                                             ALUOp[3:0],ALUSrc}
//                readM, writeM, address    - memory request / address
//                data (inout)              - memory data, driven while writeM
//                inputReady, ackOutput     - read-data valid / write accepted
//                instruction, num_inst     - IR and retired-instruction count
//                output_port               - WWD output register
//  Options     : `define DATAPATH_WWD_EN enables the WWD output register;
//                without it WWD retires as a NOP and output_port is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_datapath
  import datapath_pkg::*;
#(
  parameter int                      WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0]    RESET_PC  = '0,
  parameter int unsigned             LINK_REG  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CTL_WIDTH-1:0] controls,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [WORD_SIZE-1:0] output_port
);

  localparam logic [WORD_SIZE-1:0]  ONE      = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [REG_ADDR_W-1:0] LINK_IDX = LINK_REG[REG_ADDR_W-1:0];

  state_t state, next_state;

  logic                 r_read_m, r_write_m, w_read_m_nxt, w_write_m_nxt;
  logic [WORD_SIZE-1:0] r_pc, r_instr, r_mdr, r_alu_out, r_num_inst;
  logic                 r_jump, r_branch, r_mem_to_reg, r_reg_dst, r_reg_write;

  // Instruction fields
  logic [3:0]            w_op;
  logic [REG_ADDR_W-1:0] w_rs, w_rt, w_rd;
  logic [5:0]            w_func;
  logic [7:0]            w_imm;
  logic [11:0]           w_target;
  assign w_op     = r_instr[15:12];
  assign w_rs     = r_instr[11:10];
  assign w_rt     = r_instr[9:8];
  assign w_rd     = r_instr[7:6];
  assign w_func   = r_instr[5:0];
  assign w_imm    = r_instr[7:0];
  assign w_target = r_instr[11:0];

  logic [WORD_SIZE-1:0] w_sext, w_lhi, w_pc_inc;
  assign w_sext   = {{(WORD_SIZE-8){w_imm[7]}}, w_imm};
  assign w_lhi    = {{(WORD_SIZE-16){1'b0}}, w_imm, 8'h00};
  assign w_pc_inc = r_pc + ONE;

  logic w_is_rtype, w_is_reg_jump, w_is_link;
  assign w_is_rtype    = (w_op == OP_RTYPE);
  assign w_is_reg_jump = w_is_rtype && ((w_func == FN_JPR) || (w_func == FN_JRL));
  assign w_is_link     = (w_op == OP_JAL) || (w_is_rtype && (w_func == FN_JRL));

  // Register file
  logic [WORD_SIZE-1:0]  w_rs_val, w_rt_val, w_rf_wdata;
  logic [REG_ADDR_W-1:0] w_rf_waddr;
  logic                  w_rf_we;

  datapath_regfile #(.WORD_SIZE(WORD_SIZE)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (w_rs),
    .raddr2 (w_rt),
    .rdata1 (w_rs_val),
    .rdata2 (w_rt_val),
    .we     (w_rf_we),
    .waddr  (w_rf_waddr),
    .wdata  (w_rf_wdata)
  );

  // ALU, evaluated in EX with the live control word
  logic [WORD_SIZE-1:0] w_alu_b, w_alu_y;
  assign w_alu_b = controls[CTL_ALUSRC] ? w_sext : w_rt_val;

  always_comb begin
    w_alu_y = '0;
    case (controls[CTL_ALUOP_HI:CTL_ALUOP_LO])
      ALU_ADD: w_alu_y = w_rs_val + w_alu_b;
      ALU_SUB: w_alu_y = w_rs_val - w_alu_b;
      ALU_AND: w_alu_y = w_rs_val & w_alu_b;
      ALU_OR:  w_alu_y = w_rs_val | w_alu_b;
      ALU_NOT: w_alu_y = ~w_rs_val;
      ALU_TCP: w_alu_y = ~w_rs_val + ONE;
      ALU_SHL: w_alu_y = w_rs_val << 1;
      ALU_SHR: w_alu_y = $signed(w_rs_val) >>> 1;
      default: w_alu_y = '0;
    endcase
  end

  // Branch condition; RF is stable until the WB edge, so it is evaluated there
  logic w_taken;
  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OP_BNE:  w_taken = (w_rs_val != w_rt_val);
      OP_BEQ:  w_taken = (w_rs_val == w_rt_val);
      OP_BGZ:  w_taken = !w_rs_val[WORD_SIZE-1] && (|w_rs_val);
      OP_BLZ:  w_taken = w_rs_val[WORD_SIZE-1];
      default: w_taken = 1'b0;
    endcase
  end

  logic [WORD_SIZE-1:0] w_next_pc;
  always_comb begin
    w_next_pc = w_pc_inc;
    if (w_is_reg_jump) begin
      w_next_pc = w_rs_val;
    end else if (r_jump && ((w_op == OP_JMP) || (w_op == OP_JAL))) begin
      w_next_pc = {r_pc[WORD_SIZE-1:12], w_target};
    end else if (r_branch && w_taken) begin
      w_next_pc = w_pc_inc + w_sext;
    end
  end

  // Write-back selection
  assign w_rf_we    = (state == S_WB) && (r_reg_write || w_is_link);
  assign w_rf_waddr = w_is_link ? LINK_IDX : (r_reg_dst ? w_rd : w_rt);
  always_comb begin
    w_rf_wdata = r_alu_out;
    if (w_is_link)              w_rf_wdata = w_pc_inc;
    else if (w_op == OP_LHI)    w_rf_wdata = w_lhi;
    else if (r_mem_to_reg)      w_rf_wdata = r_mdr;
  end

  // Handshakes only count while the matching request is actually asserted
  logic w_fetch_done, w_mem_rd_done, w_mem_wr_done;
  assign w_fetch_done  = (state == S_IF)  && r_read_m  && inputReady;
  assign w_mem_rd_done = (state == S_MEM) && r_read_m  && inputReady;
  assign w_mem_wr_done = (state == S_MEM) && r_write_m && ackOutput;

  // Next state and next request strobes. readM/writeM are registered so the
  // cycle after reset is quiet; the first fetch request rises one cycle later.
  always_comb begin
    next_state    = state;
    w_read_m_nxt  = 1'b0;
    w_write_m_nxt = 1'b0;
    case (state)
      S_IF: begin
        if (w_fetch_done) next_state = S_EX;
        else              w_read_m_nxt = 1'b1;
      end
      S_EX: begin
        if (controls[CTL_MEMREAD]) begin
          next_state   = S_MEM;
          w_read_m_nxt = 1'b1;
        end else if (controls[CTL_MEMWRITE]) begin
          next_state    = S_MEM;
          w_write_m_nxt = 1'b1;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        if (w_mem_rd_done || w_mem_wr_done) begin
          next_state = S_WB;
        end else begin
          w_read_m_nxt  = r_read_m;
          w_write_m_nxt = r_write_m;
        end
      end
      S_WB: begin
        next_state   = S_IF;
        w_read_m_nxt = 1'b1;
      end
      default: next_state = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IF;
      r_read_m     <= 1'b0;
      r_write_m    <= 1'b0;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_mdr        <= '0;
      r_alu_out    <= '0;
      r_num_inst   <= '0;
      r_jump       <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_reg_write  <= 1'b0;
    end else begin
      state     <= next_state;
      r_read_m  <= w_read_m_nxt;
      r_write_m <= w_write_m_nxt;
      if (w_fetch_done) r_instr <= data;
      if (state == S_EX) begin
        r_alu_out    <= w_alu_y;
        r_jump       <= controls[CTL_JUMP];
        r_branch     <= controls[CTL_BRANCH];
        r_mem_to_reg <= controls[CTL_MEMTOREG];
        r_reg_dst    <= controls[CTL_REGDST];
        r_reg_write  <= controls[CTL_REGWRITE];
      end
      if (w_mem_rd_done) r_mdr <= data;
      if (state == S_WB) begin
        r_pc       <= w_next_pc;
        r_num_inst <= r_num_inst + ONE;
      end
    end
  end

`ifdef DATAPATH_WWD_EN
  logic r_wwd_unused;
  logic [WORD_SIZE-1:0] r_output_port;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_output_port <= '0;
    end else if ((state == S_WB) && w_is_rtype && (w_func == FN_WWD)) begin
      r_output_port <= w_rs_val;
    end
  end
  assign output_port = r_output_port;
`else
  assign output_port = '0;
`endif

  assign readM       = r_read_m;
  assign writeM      = r_write_m;
  assign address     = (state == S_IF) ? r_pc : r_alu_out;
  assign data        = r_write_m ? w_rt_val : {WORD_SIZE{1'bz}};
  assign instruction = r_instr;
  assign num_inst    = r_num_inst;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_datapath
//  Description : Self-checking bench for multicycle_datapath. Plays the role
//                of memory and control unit; expected fetch addresses and
//                store data are queued when each instruction is issued and
//                compared when the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] controls;
  wire         readM, writeM;
  wire  [15:0] address, instruction, num_inst, output_port;
  wire  [15:0] data;
  logic        inputReady, ackOutput;
  logic [15:0] tb_data;
  logic        tb_drive;

  assign data = tb_drive ? tb_data : 16'hzzzz;

  always #5 clk = ~clk;

  multicycle_datapath #(.WORD_SIZE(16), .RESET_PC(16'h0000), .LINK_REG(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .controls    (controls),
    .readM       (readM),
    .writeM      (writeM),
    .address     (address),
    .data        (data),
    .inputReady  (inputReady),
    .ackOutput   (ackOutput),
    .instruction (instruction),
    .num_inst    (num_inst),
    .output_port (output_port)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] pc_q[$];
  logic [15:0] wdata_q[$];
  logic [15:0] mpc;
  int          retired;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Wait for the next fetch request; check its address and the retire count.
  task automatic await_fetch();
    int n = 0;
    logic [15:0] e;
    while (readM !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (readM !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: readM=%b required 1", readM);
    end
    if (pc_q.size() > 0) begin
      e = pc_q.pop_front();
      checks++;
      if (address !== e) begin
        errors++;
        $display("FAIL fetch_pc: address=%h required %h", address, e);
      end
    end
    checks++;
    if (num_inst !== retired[15:0]) begin
      errors++;
      $display("FAIL num_inst: got %0d required %0d", num_inst, retired);
    end
  endtask

  // Issue one instruction: fetch (fdelay wait cycles), optional memory phase.
  task automatic run_instr(input logic [15:0] ins, input logic [11:0] ctl,
                           input int fdelay, input int mdelay,
                           input logic [15:0] rdata, input logic [15:0] maddr,
                           input logic [15:0] wdata, input logic [15:0] next_pc);
    int hi = 0;
    int n  = 0;
    logic [15:0] e;
    await_fetch();
    for (int k = 0; k < fdelay; k++) begin
      if (readM === 1'b1) hi++;
      @(negedge clk);
    end
    if (readM === 1'b1) hi++;
    controls   = ctl;
    tb_data    = ins;
    tb_drive   = 1'b1;
    inputReady = 1'b1;
    pc_q.push_back(next_pc);
    if (ctl[7]) wdata_q.push_back(wdata);
    @(negedge clk);
    inputReady = 1'b0;
    tb_drive   = 1'b0;
    checks++;
    if (readM !== 1'b0) begin
      errors++;
      $display("FAIL readM_drop: readM=%b required 0", readM);
    end
    checks++;
    if (instruction !== ins) begin
      errors++;
      $display("FAIL ir_latch: instruction=%h required %h", instruction, ins);
    end
    checks++;
    if (hi != fdelay + 1) begin
      errors++;
      $display("FAIL fetch_len: readM high %0d cycles required %0d", hi, fdelay + 1);
    end
    if (ctl[8] || ctl[7]) begin
      while (readM !== 1'b1 && writeM !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (address !== maddr) begin
        errors++;
        $display("FAIL mem_addr: address=%h required %h", address, maddr);
      end
      hi = 0;
      if (ctl[7]) begin
        for (int k = 0; k < mdelay; k++) begin
          if (writeM === 1'b1) hi++;
          @(negedge clk);
        end
        if (writeM === 1'b1) hi++;
        e = wdata_q.pop_front();
        checks++;
        if (data !== e) begin
          errors++;
          $display("FAIL store_data: data=%h required %h", data, e);
        end
        ackOutput = 1'b1;
        @(negedge clk);
        ackOutput = 1'b0;
        checks++;
        if (writeM !== 1'b0 || hi != mdelay + 1) begin
          errors++;
          $display("FAIL write_len: writeM=%b high %0d cycles required 0/%0d",
                   writeM, hi, mdelay + 1);
        end
      end else begin
        for (int k = 0; k < mdelay; k++) begin
          if (readM === 1'b1) hi++;
          @(negedge clk);
        end
        if (readM === 1'b1) hi++;
        tb_data    = rdata;
        tb_drive   = 1'b1;
        inputReady = 1'b1;
        @(negedge clk);
        inputReady = 1'b0;
        tb_drive   = 1'b0;
        checks++;
        if (readM !== 1'b0 || hi != mdelay + 1) begin
          errors++;
          $display("FAIL read_len: readM=%b high %0d cycles required 0/%0d",
                   readM, hi, mdelay + 1);
        end
      end
    end
    retired++;
    mpc = next_pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; inputReady = 1'b0; ackOutput = 1'b0;
    tb_drive = 1'b0; tb_data = 16'h0000; controls = 12'h000;
    repeat (3) @(negedge clk);
    checks++;
    if (readM !== 1'b0 || writeM !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: readM=%b writeM=%b required 0 0", readM, writeM);
    end
    checks++;
    if (address !== 16'h0000 || num_inst !== 16'h0000) begin
      errors++;
      $display("FAIL reset_pc: address=%h num_inst=%h required 0000 0000", address, num_inst);
    end
    checks++;
    if (instruction !== 16'h0000 || output_port !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: instruction=%h output_port=%h required 0 0",
               instruction, output_port);
    end
    // Spurious inputReady with no request pending must be ignored
    reset = 1'b0; inputReady = 1'b1; tb_drive = 1'b1; tb_data = 16'hDEAD;
    @(negedge clk);
    inputReady = 1'b0; tb_drive = 1'b0;
    checks++;
    if (instruction !== 16'h0000 || readM !== 1'b1) begin
      errors++;
      $display("FAIL stray_ready: instruction=%h readM=%b required 0000 1", instruction, readM);
    end
    // Reset while the fetch request is pending
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (readM !== 1'b0 || address !== 16'h0000 || num_inst !== 16'h0000) begin
      errors++;
      $display("FAIL reset_abort: readM=%b address=%h num_inst=%h required 0 0000 0000",
               readM, address, num_inst);
    end
    reset = 1'b0;
    pc_q.delete();
    wdata_q.delete();
    pc_q.push_back(16'h0000);
    mpc = 16'h0000;
    retired = 0;
  endtask

  task automatic test_fetch_delay();
    run_instr(16'h4000, 12'h021, 3, 0, 16'h0, 16'h0, 16'h0, mpc + 16'd1); // ADI r0,r0,0
  endtask

  task automatic test_store();
    run_instr(16'h6112, 12'h020, 0, 0, 16'h0, 16'h0, 16'h0, mpc + 16'd1);          // LHI r1,0x12
    run_instr(16'h8140, 12'h081, 0, 2, 16'h0, 16'h0040, 16'h1200, mpc + 16'd1);    // SWD r1,0x40(r0)
  endtask

  task automatic test_load();
    run_instr(16'h7120, 12'h321, 1, 1, 16'h1357, 16'h0020, 16'h0, mpc + 16'd1);    // LWD r1,0x20(r0)
    run_instr(16'h8120, 12'h081, 0, 0, 16'h0, 16'h0020, 16'h1357, mpc + 16'd1);    // SWD r1,0x20(r0)
  endtask

  task automatic test_branch();
    run_instr(16'h55FF, 12'h027, 0, 0, 16'h0, 16'h0, 16'h0, mpc + 16'd1);   // ORI r1 -> FFFF
    run_instr(16'h9010, 12'h800, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0010);      // JMP 0x010
    run_instr(16'h34FE, 12'h400, 0, 0, 16'h0, 16'h0, 16'h0, 16'h000F);      // BLZ r1 taken
    run_instr(16'h9010, 12'h800, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0010);      // JMP 0x010
    run_instr(16'h30FE, 12'h400, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0011);      // BLZ r0 not taken
    run_instr(16'h0405, 12'h400, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0017);      // BNE r1,r0 taken
  endtask

  task automatic test_jal_wrap();
    run_instr(16'h63F1, 12'h020, 0, 0, 16'h0, 16'h0, 16'h0, mpc + 16'd1);   // LHI r3,0xF1
    run_instr(16'h4F23, 12'h021, 0, 0, 16'h0, 16'h0, 16'h0, mpc + 16'd1);   // ADI r3 -> F123
    run_instr(16'hFC19, 12'h800, 0, 0, 16'h0, 16'h0, 16'h0, 16'hF123);      // JPR r3
    run_instr(16'hA045, 12'h820, 0, 0, 16'h0, 16'h0, 16'h0, 16'hF045);      // JAL 0x045
    run_instr(16'h8200, 12'h081, 0, 0, 16'h0, 16'h0000, 16'hF124, mpc + 16'd1); // SWD r2
    run_instr(16'hF6C0, 12'h060, 0, 0, 16'h0, 16'h0, 16'h0, mpc + 16'd1);   // ADD r3=r1+r2
    run_instr(16'h8300, 12'h081, 0, 1, 16'h0, 16'h0000, 16'hF123, mpc + 16'd1); // SWD r3
    run_instr(16'hF419, 12'h800, 0, 0, 16'h0, 16'h0, 16'h0, 16'hFFFF);      // JPR r1
    run_instr(16'h4000, 12'h021, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0000);      // PC wraps
  endtask

  task automatic test_wwd();
    logic [15:0] exp_out;
    run_instr(16'h63BF, 12'h020, 0, 0, 16'h0, 16'h0, 16'h0, mpc + 16'd1);   // LHI r3,0xBF
    run_instr(16'h4FEF, 12'h021, 0, 0, 16'h0, 16'h0, 16'h0, mpc + 16'd1);   // ADI r3 -> BEEF
    run_instr(16'hFC1C, 12'h000, 0, 0, 16'h0, 16'h0, 16'h0, mpc + 16'd1);   // WWD r3
    await_fetch();
`ifdef DATAPATH_WWD_EN
    exp_out = 16'hBEEF;
`else
    exp_out = 16'h0000;
`endif
    checks++;
    if (output_port !== exp_out) begin
      errors++;
      $display("FAIL wwd_out: output_port=%h required %h", output_port, exp_out);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_delay();
    test_store();
    test_load();
    test_branch();
    test_jal_wrap();
    test_wwd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
